// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, default burst length and port ids shared by mem_arbiter.
package mem_arb_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD_WAIT,
        S_BURST,
        S_STORE_WAIT,
        S_DONE
    } state_t;
    localparam int   LINE_WORDS_DEF = 8;
    localparam logic PORT_I         = 1'b0;
    localparam logic PORT_D         = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; the pointer remembers the last port served.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic last;
    always_ff @(posedge clk or posedge rst)
        if (rst) last <= PORT_I;
        else if (en && |req) last <= gnt[PORT_D];
    // on contention the port not served last wins
    assign gnt[PORT_D] = req[PORT_D] & (!req[PORT_I] | (last == PORT_I));
    assign gnt[PORT_I] = req[PORT_I] & !gnt[PORT_D];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D arbiter in front of one line-burst memory port.
// Defining MEM_ARB_TIMEOUT_EN adds a watchdog and the ERR output.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_WORDS     = LINE_WORDS_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          I_REQ,
    input  logic [31:0]                   I_ADDR,
    output logic                          I_GNT,
    input  logic                          D_REQ,
    input  logic                          D_WE,
    input  logic [31:0]                   D_ADDR,
    input  logic [31:0]                   D_WDATA,
    output logic                          D_GNT,
    output logic                          RVALID,
    output logic [31:0]                   RDATA,
    output logic [$clog2(LINE_WORDS)-1:0] RBEAT,
    output logic                          RSEL,
    output logic                          DONE,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic                          ERR,
`endif
    output logic                          MEM_VALID,
    output logic                          MEM_LOAD,
    output logic                          MEM_STORE,
    output logic [31:0]                   MEM_ADDR,
    output logic [31:0]                   MEM_WDATA,
    input  logic                          MEM_READY,
    input  logic [31:0]                   MEM_RDATA
);
    localparam int          BW        = $clog2(LINE_WORDS);
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

    state_t        state, nxt;
    logic [1:0]    gnt;
    logic [31:0]   addr_q, wdata_q;
    logic          sel_q, beat, last_beat, tmo;
    logic [BW-1:0] cnt;

    rr_arb2 u_arb (
        .clk(CLK),
        .rst(RST),
        .req({D_REQ, I_REQ}),
        .en (state == S_ARB),
        .gnt(gnt)
    );

    assign beat      = state == S_BURST && MEM_READY;
    assign last_beat = beat && cnt == BW'(LINE_WORDS - 1);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd;
    logic          waiting;
    // counts idle memory cycles; any MEM_READY restarts the count
    assign waiting = state inside {S_LOAD_WAIT, S_BURST, S_STORE_WAIT};
    assign tmo     = waiting && !MEM_READY && wd == WW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            wd  <= '0;
            ERR <= 1'b0;
        end else begin
            wd  <= (waiting && !MEM_READY) ? wd + 1'b1 : '0;
            ERR <= tmo;
        end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= S_IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:       nxt = (I_REQ || D_REQ) ? S_ARB : S_IDLE;
            S_ARB:        nxt = !(|gnt) ? S_IDLE : (gnt[PORT_D] && D_WE) ? S_STORE_WAIT : S_LOAD_WAIT;
            S_LOAD_WAIT:  nxt = MEM_READY ? S_BURST : tmo ? S_DONE : S_LOAD_WAIT;
            S_BURST:      nxt = (last_beat || tmo) ? S_DONE : S_BURST;
            S_STORE_WAIT: nxt = (MEM_READY || tmo) ? S_DONE : S_STORE_WAIT;
            default:      nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= 1'b0;
            cnt     <= '0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RBEAT   <= '0;
        end else begin
            if (state == S_ARB && |gnt) begin
                sel_q   <= gnt[PORT_D];
                addr_q  <= gnt[PORT_D] ? D_ADDR : I_ADDR;
                wdata_q <= D_WDATA;
                cnt     <= '0;
            end
            RVALID <= beat;
            if (beat) begin
                RDATA <= MEM_RDATA;
                RBEAT <= cnt;
                cnt   <= cnt + 1'b1;
            end
        end

    always_comb begin
        I_GNT     = state == S_ARB && gnt[PORT_I];
        D_GNT     = state == S_ARB && gnt[PORT_D];
        RSEL      = (state == S_ARB) ? gnt[PORT_D] : sel_q;
        DONE      = state == S_DONE;
        MEM_LOAD  = state inside {S_LOAD_WAIT, S_BURST};
        MEM_STORE = state == S_STORE_WAIT;
        MEM_VALID = MEM_LOAD || MEM_STORE;
        MEM_ADDR  = MEM_LOAD ? (addr_q & ~LINE_MASK) : MEM_STORE ? (addr_q & ~32'h3) : '0;
        MEM_WDATA = MEM_STORE ? wdata_q : '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a rule-level reference model.
// Defining MEM_ARB_TIMEOUT_EN also exercises the watchdog and ERR.
module tb_mem_arbiter;
    logic        CLK, RST;
    logic        I_REQ, I_GNT, D_REQ, D_WE, D_GNT;
    logic [31:0] I_ADDR, D_ADDR, D_WDATA;
    logic        RVALID, RSEL, DONE;
    logic [31:0] RDATA;
    logic [2:0]  RBEAT;
    logic        MEM_VALID, MEM_LOAD, MEM_STORE, MEM_READY;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        ERR;
`endif

    mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_GNT(D_GNT),
        .RVALID(RVALID), .RDATA(RDATA), .RBEAT(RBEAT), .RSEL(RSEL), .DONE(DONE),
`ifdef MEM_ARB_TIMEOUT_EN
        .ERR(ERR),
`endif
        .MEM_VALID(MEM_VALID), .MEM_LOAD(MEM_LOAD), .MEM_STORE(MEM_STORE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_READY(MEM_READY), .MEM_RDATA(MEM_RDATA)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {bit done; bit sel; int beat; logic [31:0] data; bit err;} rexp_t;
    typedef struct {bit store; logic [31:0] addr; logic [31:0] wdata;} mexp_t;
    rexp_t rq[$];
    mexp_t mq[$];
    bit    gq[$];
    int    total = 0, bad = 0;
    bit    last_d = 0;
    bit    fast = 0, mem_off = 0;
    int    stall_at = -1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h40) >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // memory: first READY of a load acknowledges, the next LINE_WORDS carry data
    int k = 0, stall_cnt = 0;
    bit hs = 0;
    always @(negedge CLK) begin
        if (hs) k++;
        if (!MEM_VALID) begin
            k = 0;
            stall_cnt = 0;
        end
        hs = MEM_VALID && !mem_off;
        if (hs && stall_at >= 0 && k == stall_at + 1 && stall_cnt < 2) begin
            hs = 0;
            stall_cnt++;
        end else if (hs && !fast) hs = ($urandom_range(3) != 0);
        MEM_READY = hs;
        MEM_RDATA = (k >= 1) ? memfn(MEM_ADDR + 32'(4 * (k - 1))) : $urandom;
    end

    // monitor: pops the scoreboard whenever the DUT presents something
    int    cyc = 0, last_g = -100;
    bit    pv = 0, eg;
    rexp_t er;
    mexp_t em;
    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            pv = 0;
            last_g = -100;
        end else begin
            if (I_GNT || D_GNT) begin
                chk("gnt_gap_ge3", 32'(cyc - last_g >= 3), 1);
                last_g = cyc;
                if (gq.size() == 0) chk("gnt_unexpected", {D_GNT, I_GNT}, 0);
                else begin
                    eg = gq.pop_front();
                    chk("gnt_side", {D_GNT, I_GNT}, eg ? 2 : 1);
                    chk("rsel_at_gnt", RSEL, eg);
                end
            end
            if (MEM_VALID) chk("mem_excl", MEM_LOAD && MEM_STORE, 0);
            if (MEM_VALID && !pv) begin
                if (mq.size() == 0) chk("mem_unexpected", MEM_ADDR, 32'hFFFF_FFFF);
                else begin
                    em = mq.pop_front();
                    chk("mem_store", MEM_STORE, em.store);
                    chk("mem_load", MEM_LOAD, !em.store);
                    chk("mem_addr", MEM_ADDR, em.addr);
                    if (em.store) chk("mem_wdata", MEM_WDATA, em.wdata);
                end
            end
            pv = MEM_VALID;
            if (RVALID) begin
                if (rq.size() == 0) chk("beat_unexpected", RDATA, 32'hFFFF_FFFF);
                else begin
                    er = rq.pop_front();
                    chk("beat_kind", er.done, 0);
                    chk("rdata", RDATA, er.data);
                    chk("rbeat", RBEAT, er.beat);
                    chk("rsel_beat", RSEL, er.sel);
                end
            end
            if (DONE) begin
                if (rq.size() == 0) chk("done_unexpected", DONE, 0);
                else begin
                    er = rq.pop_front();
                    chk("done_kind", er.done, 1);
                    chk("rsel_done", RSEL, er.sel);
`ifdef MEM_ARB_TIMEOUT_EN
                    chk("err", ERR, er.err);
`endif
                end
            end
        end
    end

    task automatic push_txn(input bit sel, input bit we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] base;
        gq.push_back(sel);
        if (we) begin
            mq.push_back('{1'b1, a & ~32'h3, wd});
            rq.push_back('{1'b1, sel, 0, 32'h0, 1'b0});
        end else begin
            base = a & ~32'h1F;
            mq.push_back('{1'b0, base, 32'h0});
            for (int i = 0; i < 8; i++) rq.push_back('{1'b0, sel, i, memfn(base + 32'(4 * i)), 1'b0});
            rq.push_back('{1'b1, sel, 0, 32'h0, 1'b0});
        end
    endtask

    task automatic wait_grants();
        int n = 0;
        bit gi, gd;
        while ((I_REQ || D_REQ) && n < 3000) begin
            @(negedge CLK);
            n++;
            gi = I_GNT;
            gd = D_GNT;
            if (gi || gd) begin
                @(posedge CLK);
                #1;
                if (gi) I_REQ = 0;
                if (gd) D_REQ = 0;
            end
        end
        chk("grant_timeout", {I_REQ, D_REQ}, 0);
        I_REQ = 0;
        D_REQ = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((rq.size() + mq.size() + gq.size()) != 0 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_timeout", rq.size() + mq.size() + gq.size(), 0);
        rq.delete();
        mq.delete();
        gq.delete();
    endtask

    // reference arbitration: on contention the side not served last goes first
    task automatic round(input bit ri, input bit rd, input logic [31:0] ia, input logic [31:0] da,
                         input bit we, input logic [31:0] wdat);
        bit first_d;
        first_d = !last_d;
        if (ri && rd) begin
            if (first_d) begin
                push_txn(1, we, da, wdat);
                push_txn(0, 0, ia, 0);
            end else begin
                push_txn(0, 0, ia, 0);
                push_txn(1, we, da, wdat);
            end
            last_d = !first_d;
        end else if (ri) begin
            push_txn(0, 0, ia, 0);
            last_d = 0;
        end else if (rd) begin
            push_txn(1, we, da, wdat);
            last_d = 1;
        end
        @(negedge CLK);
        I_REQ = ri; I_ADDR = ia;
        D_REQ = rd; D_ADDR = da; D_WE = we; D_WDATA = wdat;
        wait_grants();
        wait_drain();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {I_GNT, D_GNT, RVALID, RSEL, DONE, MEM_VALID, MEM_LOAD, MEM_STORE}, 0);
        chk({tag, "_rdata"}, RDATA, 0);
        chk({tag, "_rbeat"}, RBEAT, 0);
        chk({tag, "_maddr"}, MEM_ADDR, 0);
        chk({tag, "_mwdata"}, MEM_WDATA, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, rv, span, mode;
        bit seen;
        RST = 1; I_REQ = 0; D_REQ = 0; D_WE = 0;
        I_ADDR = 0; D_ADDR = 0; D_WDATA = 0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 0;
        // contention after reset, both held: D, I, D, I
        round(1, 1, 32'h0000_0080, 32'h0000_0400, 0, 0);
        round(1, 1, 32'h0000_00C4, 32'h0000_0520, 0, 0);
        // directed I-fill and D-store
        fast = 1;
        round(1, 0, 32'h0000_0044, 0, 0, 0);
        round(0, 1, 0, 32'h0000_0103, 1, 32'hDEAD_BEEF);
        // stall two cycles before beat 3
        stall_at = 3;
        push_txn(1, 0, 32'h0000_1234, 0);
        last_d = 1;
        @(negedge CLK);
        D_REQ = 1; D_ADDR = 32'h0000_1234; D_WE = 0;
        wait_grants();
        n = 0; rv = 0; span = 0; seen = 0;
        while (!DONE && n < 300) begin
            @(negedge CLK);
            n++;
            if (RVALID) begin
                rv++;
                seen = 1;
            end
            if (seen) span++;
        end
        chk("stall_beats", rv, 8);
        chk("stall_span", span, 10);
        wait_drain();
        stall_at = -1;
        fast = 0;
        for (int r = 0; r < 25; r++) begin
            mode = $urandom_range(1, 3);
            round(mode[0], mode[1], $urandom, $urandom, 1'($urandom_range(1)), $urandom);
        end
        // reset at beat 3 of a D fill; pointer must again favour D afterwards
        push_txn(1, 0, 32'h0000_0200, 0);
        @(negedge CLK);
        D_REQ = 1; D_ADDR = 32'h0000_0200; D_WE = 0;
        wait_grants();
        n = 0;
        while (!(RVALID && RBEAT == 3) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("beat3_seen", {RVALID, RBEAT}, 4'hB);
        #1 RST = 1;
        #1 check_all_zero("midreset");
        rq.delete(); mq.delete(); gq.delete();
        last_d = 0;
        repeat (3) @(negedge CLK);
        RST = 0;
        repeat (5) @(negedge CLK);
        round(1, 1, 32'h0000_0660, 32'h0000_0700, 0, 0);
`ifdef MEM_ARB_TIMEOUT_EN
        mem_off = 1;
        gq.push_back(0);
        mq.push_back('{1'b0, 32'h0000_0300, 32'h0});
        rq.push_back('{1'b1, 1'b0, 0, 32'h0, 1'b1});
        last_d = 0;
        @(negedge CLK);
        I_REQ = 1; I_ADDR = 32'h0000_0300;
        wait_grants();
        n = 0;
        while (!DONE && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("timeout_cycles", n, 65);
        wait_drain();
        mem_off = 0;
`endif
        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
